mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the request unit and caches. Takes the instruction-fetch request (iREN/iaddr) and the data request (dREN/dWEN/daddr/dstore), arbitrates them onto the single-ported RAM, and returns wait/load to each requester.
- Data requests have priority. A starvation counter guarantees forward progress for fetch.
- A per-transaction timeout and the RAM ERROR state are folded into a sticky error flag, so the core never hangs.

Parameters:
- STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before fetch is forced next
- TIMEOUT, 64, max cycles in a RAM transaction before abort
- ERR_WORD, 32'hBAD1BAD1, value returned on load when a transaction errors or times out

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous reset, active-high
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- dREN  in  1  data read request
- dWEN  in  1  data write request (dREN&dWEN together is treated as a write)
- daddr  in  32  data address
- dstore  in  32  data write value
- iwait  out  1  fetch not complete this cycle
- dwait  out  1  data access not complete this cycle
- iload  out  32  fetched instruction, valid when iREN&!iwait
- dload  out  32  read data, valid when dREN&!dwait
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- err  out  1  sticky: set on timeout or ERROR, cleared only by RST

Behaviour:
- States:
  - IDLE: no RAM operation.
  - DGNT: data transaction.
  - IGNT: fetch transaction.
- RAM outputs come only from registers:
  - addr/store/op are latched at grant.
  - ramREN/ramWEN are high only in DGNT/IGNT.
  - ramaddr/ramstore hold constant for the whole transaction.
- IDLE arbitration, evaluated each cycle:
  - If (dREN|dWEN) and not (iREN && starve==STARVE_MAX): go to DGNT. If iREN is pending, starve++, saturating at STARVE_MAX.
  - Else if iREN: go to IGNT and set starve=0.
  - Else stay IDLE. If !iREN, set starve=0.
- Transaction completion, in DGNT or IGNT:
  - ramstate==ACCESS completes the transaction. The owner's wait goes low combinationally in that same cycle, and its load = ramload (writes: dload=0). Next state is IDLE.
  - ramstate==ERROR, or the tcount reaching TIMEOUT-1, also completes it. Wait goes low, load = ERR_WORD, err<=1, ramREN/ramWEN drop next cycle, next state IDLE.
  - FREE or BUSY means keep waiting and increment tcount. tcount resets to 0 on every grant.
- Wait outputs:
  - iwait = iREN & !(state==IGNT & completing).
  - dwait = (dREN|dWEN) & !(state==DGNT & completing).
  - Wait is 0 when no request is asserted.
- Abort: if the owner drops its request while granted, go to IDLE next cycle. The RAM strobe drops, no load is returned, and err is unaffected.
- Request change mid-grant: changing daddr/iaddr mid-grant has no effect, because the latched address is used.
- Back-to-back: a request held after completion is re-arbitrated from IDLE. Minimum latency is 2 cycles (IDLE grant + ACCESS cycle) per access.
- Simultaneous iREN and dREN in IDLE goes to data, unless the starvation counter is at STARVE_MAX.
- Reset, including mid-transaction:
  - state=IDLE, starve=0, tcount=0, err=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - iload=dload=0; iwait=iREN, dwait=dREN|dWEN.
- Width: starve is clog2(STARVE_MAX+1) bits and tcount is clog2(TIMEOUT) bits, both unsigned and saturating.

Test Plan:
- Reset with iREN=1 high: RAM strobes 0, err=0, iwait=1. Release RST with ramstate=ACCESS and ramload=32'h8C010004: IGNT next cycle, the cycle after that iwait=0 and iload=32'h8C010004.
- iREN and dREN both asserted, daddr=32'h100, RAM ACCESS on 2nd cycle of every grant: first grant goes to DGNT (ramaddr=32'h100, ramREN=1). After 4 data grants with iREN held, the 5th grant is IGNT.
- dWEN=1, daddr=32'h200, dstore=32'hDEADBEEF, ramstate BUSY 3 cycles then ACCESS: ramWEN=1, ramaddr=32'h200, ramstore=32'hDEADBEEF held all 4 cycles; dwait low only in the ACCESS cycle.
- ramstate held BUSY during a read: after 64 cycles dwait=0, dload=32'hBAD1BAD1, err=1, which stays 1 until RST.
- ramstate=ERROR on the first IGNT cycle: iwait=0, iload=32'hBAD1BAD1, err=1 that cycle+1, state IDLE.
- dREN dropped on the 2nd cycle of DGNT (ramstate BUSY): ramREN=0 next cycle, state IDLE, err=0, a pending iREN is then granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported RAM between the instruction-fetch requester and
// the data requester. Data wins ties. A starvation counter forces a fetch
// grant after STARVE_MAX consecutive data grants taken while a fetch waited.
// Every RAM transaction is bounded by a timeout. A RAM ERROR or a timeout
// completes the access with ERR_WORD and sets a sticky error flag, so the
// core can never hang on the memory.
//
// Ports
//   CLK, RST          rising-edge clock, synchronous active-high reset
//   iREN, iaddr       fetch request and word address
//   dREN, dWEN        data read / write request (both high counts as a write)
//   daddr, dstore     data address and write value
//   iwait, dwait      requester stall, low in the cycle its access completes
//   iload, dload      returned data, valid only in the completing cycle
//   ramREN, ramWEN    RAM strobes (registered)
//   ramaddr, ramstore RAM address / write data (registered, latched at grant)
//   ramload           RAM read data
//   ramstate          0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   err               sticky error flag, cleared only by RST
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0]    RS_ACCESS = 2'd2;
  localparam logic [1:0]    RS_ERROR  = 2'd3;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TCOUNT_TOP = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tcount_q, tcount_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   store_q, store_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic          err_q, err_d;

  logic          dreq;
  logic          owner_req;
  logic          done_ok;
  logic          done_err;
  logic [31:0]   result;

  assign dreq = dREN | dWEN;

  // A fresh ACCESS wins over a coincident timeout: the data is good.
  assign done_ok  = (ramstate == RS_ACCESS);
  assign done_err = !done_ok && ((ramstate == RS_ERROR) || (tcount_q == TCOUNT_TOP));

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    tcount_d  = tcount_q;
    addr_d    = addr_q;
    store_d   = store_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    err_d     = err_q;
    iwait     = iREN;
    dwait     = dreq;
    iload     = '0;
    dload     = '0;
    owner_req = 1'b0;
    result    = '0;

    // While RST is high the outputs show the reset view (no completion),
    // whatever state the registers still hold before the reset edge.
    if (!RST) begin
      unique case (state_q)
        IDLE: begin
          tcount_d = '0;
          if (dreq && !(iREN && (starve_q == STARVE_TOP))) begin
            state_d = DGNT;
            addr_d  = daddr;
            store_d = dstore;
            wen_d   = dWEN;
            ren_d   = !dWEN;
            if (iREN && (starve_q != STARVE_TOP)) begin
              starve_d = starve_q + 1'b1;
            end
          end else if (iREN) begin
            state_d  = IGNT;
            addr_d   = iaddr;
            store_d  = '0;
            ren_d    = 1'b1;
            wen_d    = 1'b0;
            starve_d = '0;
          end else begin
            starve_d = '0;
          end
        end

        DGNT, IGNT: begin
          owner_req = (state_q == DGNT) ? dreq : iREN;
          if (!owner_req) begin
            // Requester walked away: release the RAM, return nothing.
            state_d = IDLE;
            ren_d   = 1'b0;
            wen_d   = 1'b0;
          end else if (done_ok || done_err) begin
            state_d = IDLE;
            ren_d   = 1'b0;
            wen_d   = 1'b0;
            if (done_err) begin
              result = ERR_WORD;
              err_d  = 1'b1;
            end else if (state_q == DGNT && wen_q) begin
              result = '0;
            end else begin
              result = ramload;
            end
            if (state_q == DGNT) begin
              dwait = 1'b0;
              dload = result;
            end else begin
              iwait = 1'b0;
              iload = result;
            end
          end else if (tcount_q != TCOUNT_TOP) begin
            tcount_d = tcount_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tcount_q <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tcount_q <= tcount_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      err_q    <= err_d;
    end
  end

  // RAM-side outputs come straight from registers.
  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Expected values are pushed onto a
// scoreboard queue as each step is set up and popped in order when the DUT
// outputs are sampled, 1 time unit after the inputs change (mid-cycle).
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  logic [31:0] exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  mem_arbiter dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, e);
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b1; iaddr = 32'h40;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramstate = ACC; ramload = 32'h8C010004;

    // ---- 1: reset with fetch pending, then first fetch ----
    step(); step();
    push(0); push(0); push(0); push(1); push(0);
    #1;
    chk("rst_ramREN", ramREN); chk("rst_ramWEN", ramWEN); chk("rst_err", err);
    chk("rst_iwait", iwait); chk("rst_ramaddr", ramaddr);
    step();
    RST = 1'b0;
    push(1); push(0);
    #1;
    chk("t1_idle_iwait", iwait); chk("t1_idle_ramREN", ramREN);
    step();
    push(1); push(32'h40); push(0); push(32'h8C010004);
    #1;
    chk("t1_ramREN", ramREN); chk("t1_ramaddr", ramaddr);
    chk("t1_iwait", iwait); chk("t1_iload", iload);
    step();
    iREN = 1'b0;
    push(0);
    #1;
    chk("t1_after_ramREN", ramREN);
    step();

    // ---- 2: data priority and starvation limit ----
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h100; iaddr = 32'h40;
    ramstate = ACC; ramload = 32'hCAFE0001;
    for (int k = 0; k < 5; k++) begin
      push(0); push(1); push(1);
      #1;
      chk("t2_idle_ramREN", ramREN); chk("t2_idle_dwait", dwait); chk("t2_idle_iwait", iwait);
      step();
      if (k < 4) begin
        push(1); push(32'h100); push(0); push(32'hCAFE0001); push(1);
        #1;
        chk("t2_d_ramREN", ramREN); chk("t2_d_ramaddr", ramaddr); chk("t2_d_dwait", dwait);
        chk("t2_d_dload", dload); chk("t2_d_iwait", iwait);
      end else begin
        push(1); push(32'h40); push(0); push(32'hCAFE0001); push(1);
        #1;
        chk("t2_i_ramREN", ramREN); chk("t2_i_ramaddr", ramaddr); chk("t2_i_iwait", iwait);
        chk("t2_i_iload", iload); chk("t2_i_dwait", dwait);
      end
      step();
    end
    dREN = 1'b0; iREN = 1'b0;
    step();

    // ---- 3: write with BUSY x3 then ACCESS; address change mid-grant ----
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramstate = BUSY; ramload = 32'h12345678;
    push(1); push(0);
    #1;
    chk("t3_idle_dwait", dwait); chk("t3_idle_ramWEN", ramWEN);
    step();
    for (int c = 0; c < 4; c++) begin
      if (c == 1) daddr = 32'h300;
      if (c == 3) ramstate = ACC;
      push(1); push(0); push(32'h200); push(32'hDEADBEEF); push((c == 3) ? 32'h0 : 32'h1);
      #1;
      chk("t3_ramWEN", ramWEN); chk("t3_ramREN", ramREN); chk("t3_ramaddr", ramaddr);
      chk("t3_ramstore", ramstore); chk("t3_dwait", dwait);
      if (c == 3) begin
        push(0);
        chk("t3_dload", dload);
      end
      step();
    end
    dWEN = 1'b0;
    push(0);
    #1;
    chk("t3_after_ramWEN", ramWEN);
    step();

    // ---- 4: timeout on a read held BUSY ----
    dREN = 1'b1; daddr = 32'h10; ramstate = BUSY;
    step();
    for (int c = 0; c < 63; c++) begin
      push(1);
      #1;
      chk("t4_wait_dwait", dwait);
      step();
    end
    push(0); push(32'hBAD1BAD1); push(1); push(0);
    #1;
    chk("t4_to_dwait", dwait); chk("t4_to_dload", dload);
    chk("t4_to_ramREN", ramREN); chk("t4_to_err_pre", err);
    step();
    dREN = 1'b0;
    push(1); push(0);
    #1;
    chk("t4_err", err); chk("t4_ramREN", ramREN);
    step(); step(); step();
    push(1);
    #1;
    chk("t4_err_sticky", err);

    // ---- reset in the middle of a transaction ----
    dREN = 1'b1; daddr = 32'h44; ramstate = BUSY;
    step(); step();
    push(1);
    #1;
    chk("rm_ramREN", ramREN);
    RST = 1'b1;
    push(1); push(0);
    #1;
    chk("rm_dwait", dwait); chk("rm_dload", dload);
    step();
    push(0); push(0); push(0);
    #1;
    chk("rm_ramREN_after", ramREN); chk("rm_ramaddr_after", ramaddr); chk("rm_err_after", err);
    RST = 1'b0; dREN = 1'b0;
    step();

    // ---- 5: ERROR on first fetch cycle ----
    iREN = 1'b1; iaddr = 32'h80; ramstate = ERR; ramload = 32'h55555555;
    push(1);
    #1;
    chk("t5_idle_iwait", iwait);
    step();
    push(1); push(0); push(32'hBAD1BAD1); push(0);
    #1;
    chk("t5_ramREN", ramREN); chk("t5_iwait", iwait); chk("t5_iload", iload); chk("t5_err_pre", err);
    step();
    iREN = 1'b0;
    push(1); push(0);
    #1;
    chk("t5_err", err); chk("t5_ramREN_after", ramREN);
    RST = 1'b1;
    step();
    RST = 1'b0;
    push(0);
    #1;
    chk("t5_err_cleared", err);
    step();

    // ---- 6: data abort, pending fetch granted afterwards ----
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h50; iaddr = 32'h60; ramstate = BUSY; ramload = 32'hA5A5A5A5;
    step();
    push(1); push(1); push(32'h50);
    #1;
    chk("t6_d1_ramREN", ramREN); chk("t6_d1_dwait", dwait); chk("t6_d1_ramaddr", ramaddr);
    step();
    dREN = 1'b0;
    push(0); push(1);
    #1;
    chk("t6_d2_dwait", dwait); chk("t6_d2_iwait", iwait);
    step();
    ramstate = ACC;
    push(0); push(0); push(1);
    #1;
    chk("t6_abort_ramREN", ramREN); chk("t6_abort_err", err); chk("t6_abort_iwait", iwait);
    step();
    push(1); push(32'h60); push(0); push(32'hA5A5A5A5); push(0);
    #1;
    chk("t6_i_ramREN", ramREN); chk("t6_i_ramaddr", ramaddr); chk("t6_i_iwait", iwait);
    chk("t6_i_iload", iload); chk("t6_i_err", err);
    step();
    iREN = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
